// File: rtl/core_pkg.sv
// core_pkg
// Shared definitions for the integer pipeline: datapath and register-address
// widths, the branch-type encoding carried down the pipe, and the ALU
// operation encoding used by the execute stage.
// No ports (package).

package core_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  // Branch type travels with the instruction. The fourth code is unused and
  // behaves exactly like "no branch" wherever it is decoded.
  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_RSVD = 2'b11
  } br_type_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5
  } alu_op_e;

endpackage

// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if
// Bundles the EX-side inputs and MEM-side outputs of the EX/MEM stage.
//   slave  : the stage itself (consumes ex_* and mem_stall, drives the rest)
//   master : whatever feeds the stage and observes its results
// EX side  : ex_valid, ex_alu_result, ex_zero_flag, ex_rs2_data, ex_rd,
//            ex_reg_write, ex_mem_read, ex_mem_write, ex_branch_type,
//            ex_branch_target, mem_stall
// MEM side : mem_valid, mem_alu_result, mem_store_data, mem_rd,
//            mem_reg_write, mem_mem_read, mem_mem_write, fwd_en, fwd_rd,
//            fwd_data, load_use_pending, branch_taken, branch_target,
//            taken_count

interface ex_mem_stage_if;
  import core_pkg::*;

  logic            ex_valid;
  logic [XLEN-1:0] ex_alu_result;
  logic            ex_zero_flag;
  logic [XLEN-1:0] ex_rs2_data;
  logic [RA_W-1:0] ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic [1:0]      ex_branch_type;
  logic [XLEN-1:0] ex_branch_target;
  logic            mem_stall;

  logic            mem_valid;
  logic [XLEN-1:0] mem_alu_result;
  logic [XLEN-1:0] mem_store_data;
  logic [RA_W-1:0] mem_rd;
  logic            mem_reg_write;
  logic            mem_mem_read;
  logic            mem_mem_write;
  logic            fwd_en;
  logic [RA_W-1:0] fwd_rd;
  logic [XLEN-1:0] fwd_data;
  logic            load_use_pending;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic [31:0]     taken_count;

  modport master (
    output ex_valid, ex_alu_result, ex_zero_flag, ex_rs2_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_branch_type,
           ex_branch_target, mem_stall,
    input  mem_valid, mem_alu_result, mem_store_data, mem_rd,
           mem_reg_write, mem_mem_read, mem_mem_write, fwd_en, fwd_rd,
           fwd_data, load_use_pending, branch_taken, branch_target,
           taken_count
  );

  modport slave (
    input  ex_valid, ex_alu_result, ex_zero_flag, ex_rs2_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_branch_type,
           ex_branch_target, mem_stall,
    output mem_valid, mem_alu_result, mem_store_data, mem_rd,
           mem_reg_write, mem_mem_read, mem_mem_write, fwd_en, fwd_rd,
           fwd_data, load_use_pending, branch_taken, branch_target,
           taken_count
  );

endinterface

// File: rtl/ex_mem_stage_branch_resolver.sv
// branch_resolver
// Combinational BEQ/BNE decision from the branch type and the ALU zero flag.
//   branch_type in  br_type_e  branch kind of the instruction in MEM
//   zero_flag   in  1          ALU result was zero
//   taken       out 1          branch condition satisfied

module branch_resolver
  import core_pkg::*;
(
  input  br_type_e branch_type,
  input  logic     zero_flag,
  output logic     taken
);

  // BR_NONE and the reserved code both fall into the default arm.
  always_comb begin
    taken = 1'b0;
    case (branch_type)
      BR_BEQ:  taken = zero_flag;
      BR_BNE:  taken = !zero_flag;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage
// EX/MEM pipeline register. Captures the ALU result, zero flag, store data and
// control bits each cycle, resolves BEQ/BNE from the captured zero flag and
// emits a one-cycle redirect pulse, drives the MEM->EX forwarding bus and the
// load-use indication, and counts taken branches.
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset
//   bus  ex_mem_stage_if.slave  (EX-side inputs, MEM-side outputs)

module ex_mem_stage
  import core_pkg::*;
(
  input logic           clk,
  input logic           rst,
  ex_mem_stage_if.slave bus
);

  logic            mem_valid_q;
  logic [XLEN-1:0] mem_alu_result_q;
  logic [XLEN-1:0] mem_store_data_q;
  logic [RA_W-1:0] mem_rd_q;
  logic            mem_reg_write_q;
  logic            mem_mem_read_q;
  logic            mem_mem_write_q;
  br_type_e        mem_branch_type_q;
  logic            mem_zero_q;
  logic [XLEN-1:0] branch_target_q;
  logic            redirect_done_q;
  logic [31:0]     taken_count_q;

  logic            resolved_taken;
  logic            branch_taken;
  logic            cap;
  logic            ex_live;

  branch_resolver u_branch_resolver (
    .branch_type (mem_branch_type_q),
    .zero_flag   (mem_zero_q),
    .taken       (resolved_taken)
  );

  // redirect_done masks the pulse after it has fired once, so a branch that
  // sits in MEM during a stall does not redirect the front end repeatedly.
  assign branch_taken = mem_valid_q & resolved_taken & ~redirect_done_q;

  // The instruction in EX during a redirect is on the wrong path, so the
  // stage refuses it even though the pipe is not stalled.
  assign cap     = ~bus.mem_stall & ~branch_taken;
  assign ex_live = bus.ex_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid_q       <= 1'b0;
      mem_alu_result_q  <= '0;
      mem_store_data_q  <= '0;
      mem_rd_q          <= '0;
      mem_reg_write_q   <= 1'b0;
      mem_mem_read_q    <= 1'b0;
      mem_mem_write_q   <= 1'b0;
      mem_branch_type_q <= BR_NONE;
      mem_zero_q        <= 1'b0;
      branch_target_q   <= '0;
      redirect_done_q   <= 1'b0;
      taken_count_q     <= '0;
    end else begin
      if (branch_taken) begin
        taken_count_q   <= taken_count_q + 32'd1;
        redirect_done_q <= 1'b1;
      end

      if (cap) begin
        // Bubbles carry no side effects: their control bits are zeroed here
        // rather than trusting whatever EX left on the wires.
        mem_valid_q       <= ex_live;
        mem_alu_result_q  <= bus.ex_alu_result;
        mem_store_data_q  <= bus.ex_rs2_data;
        mem_rd_q          <= bus.ex_rd;
        mem_reg_write_q   <= ex_live & bus.ex_reg_write;
        mem_mem_read_q    <= ex_live & bus.ex_mem_read;
        mem_mem_write_q   <= ex_live & bus.ex_mem_write;
        mem_branch_type_q <= ex_live ? br_type_e'(bus.ex_branch_type) : BR_NONE;
        mem_zero_q        <= bus.ex_zero_flag;
        branch_target_q   <= bus.ex_branch_target;
        redirect_done_q   <= 1'b0;
      end else if (!bus.mem_stall) begin
        // Wrong-path kill: datapath values are left as-is, only the entry's
        // validity and side-effecting control bits are dropped.
        mem_valid_q       <= 1'b0;
        mem_reg_write_q   <= 1'b0;
        mem_mem_read_q    <= 1'b0;
        mem_mem_write_q   <= 1'b0;
        mem_branch_type_q <= BR_NONE;
      end
    end
  end

  assign bus.mem_valid      = mem_valid_q;
  assign bus.mem_alu_result = mem_alu_result_q;
  assign bus.mem_store_data = mem_store_data_q;
  assign bus.mem_rd         = mem_rd_q;
  assign bus.mem_reg_write  = mem_reg_write_q;
  assign bus.mem_mem_read   = mem_mem_read_q;
  assign bus.mem_mem_write  = mem_mem_write_q;

  // A load's value is not available until after the memory access, so it is
  // reported as a load-use hazard instead of being forwarded. x0 is never a
  // real dependency.
  assign bus.fwd_en           = mem_valid_q & mem_reg_write_q & ~mem_mem_read_q &
                                (mem_rd_q != '0);
  assign bus.fwd_rd           = mem_rd_q;
  assign bus.fwd_data         = mem_alu_result_q;
  assign bus.load_use_pending = mem_valid_q & mem_mem_read_q & (mem_rd_q != '0);

  assign bus.branch_taken  = branch_taken;
  assign bus.branch_target = branch_target_q;
  assign bus.taken_count   = taken_count_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage
// Self-checking bench for ex_mem_stage: a directed vector table, a counter
// wrap sequence and a long randomized run, all compared against a
// transaction-level model of the MEM entry held in the bench.

module tb_ex_mem_stage;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ex_mem_stage_if bus ();

  ex_mem_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        valid;
    logic [31:0] alu;
    logic        zero;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [1:0]  bt;
    logic [31:0] tgt;
  } stim_t;

  typedef struct {
    logic        valid;
    logic [31:0] alu;
    logic        rw;
    logic        fwd_en;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        lup;
    logic        taken;
    logic [31:0] target;
    logic [31:0] count;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  // The instruction currently sitting in MEM, as the model sees it.
  typedef struct {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [1:0]  bt;
    logic        zero;
    logic [31:0] tgt;
  } entry_t;

  entry_t      mem_entry;
  logic        redirected;
  logic [31:0] taken_total;

  int checks = 0;
  int errors = 0;

  vec_t tbl[19];

  function automatic logic modelPulse();
    logic cond;
    cond = (mem_entry.bt == 2'd1 && mem_entry.zero) ||
           (mem_entry.bt == 2'd2 && !mem_entry.zero);
    return mem_entry.valid && cond && !redirected;
  endfunction

  task automatic modelStep(input stim_t s);
    logic pulse;
    if (s.rst) begin
      mem_entry   = '{default: '0};
      redirected  = 1'b0;
      taken_total = 32'd0;
    end else begin
      pulse = modelPulse();
      if (pulse) begin
        taken_total = taken_total + 32'd1;
        redirected  = 1'b1;
      end
      if (!s.stall) begin
        if (pulse) begin
          mem_entry.valid = 1'b0;
          mem_entry.rw    = 1'b0;
          mem_entry.mr    = 1'b0;
          mem_entry.mw    = 1'b0;
          mem_entry.bt    = 2'd0;
        end else begin
          mem_entry.valid = s.valid;
          mem_entry.alu   = s.alu;
          mem_entry.data  = s.rs2;
          mem_entry.rd    = s.rd;
          mem_entry.rw    = s.valid && s.rw;
          mem_entry.mr    = s.valid && s.mr;
          mem_entry.mw    = s.valid && s.mw;
          mem_entry.bt    = s.valid ? s.bt : 2'd0;
          mem_entry.zero  = s.zero;
          mem_entry.tgt   = s.tgt;
          redirected      = 1'b0;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of EX inputs, advance the model on the same edge and
  // return on the following falling edge where outputs are stable.
  task automatic applyStimulus(input stim_t s);
    rst                  = s.rst;
    bus.mem_stall        = s.stall;
    bus.ex_valid         = s.valid;
    bus.ex_alu_result    = s.alu;
    bus.ex_zero_flag     = s.zero;
    bus.ex_rs2_data      = s.rs2;
    bus.ex_rd            = s.rd;
    bus.ex_reg_write     = s.rw;
    bus.ex_mem_read      = s.mr;
    bus.ex_mem_write     = s.mw;
    bus.ex_branch_type   = s.bt;
    bus.ex_branch_target = s.tgt;
    @(posedge clk);
    modelStep(s);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag);
    logic exp_fwd;
    logic exp_lup;
    exp_fwd = mem_entry.valid && mem_entry.rw && !mem_entry.mr && (mem_entry.rd != 5'd0);
    exp_lup = mem_entry.valid && mem_entry.mr && (mem_entry.rd != 5'd0);
    check({tag, " mem_valid"},      32'(bus.mem_valid),        32'(mem_entry.valid));
    check({tag, " mem_alu_result"}, bus.mem_alu_result,        mem_entry.alu);
    check({tag, " mem_store_data"}, bus.mem_store_data,        mem_entry.data);
    check({tag, " mem_rd"},         32'(bus.mem_rd),           32'(mem_entry.rd));
    check({tag, " mem_reg_write"},  32'(bus.mem_reg_write),    32'(mem_entry.rw));
    check({tag, " mem_mem_read"},   32'(bus.mem_mem_read),     32'(mem_entry.mr));
    check({tag, " mem_mem_write"},  32'(bus.mem_mem_write),    32'(mem_entry.mw));
    check({tag, " fwd_en"},         32'(bus.fwd_en),           32'(exp_fwd));
    check({tag, " fwd_rd"},         32'(bus.fwd_rd),           32'(mem_entry.rd));
    check({tag, " fwd_data"},       bus.fwd_data,              mem_entry.alu);
    check({tag, " load_use"},       32'(bus.load_use_pending), 32'(exp_lup));
    check({tag, " branch_taken"},   32'(bus.branch_taken),     32'(modelPulse()));
    check({tag, " branch_target"},  bus.branch_target,         mem_entry.tgt);
    check({tag, " taken_count"},    bus.taken_count,           taken_total);
  endtask

  task automatic checkTable(input int i, input exp_t e);
    string t;
    t = $sformatf("row%0d", i);
    check({t, " valid"},    32'(bus.mem_valid),        32'(e.valid));
    check({t, " alu"},      bus.mem_alu_result,        e.alu);
    check({t, " rw"},       32'(bus.mem_reg_write),    32'(e.rw));
    check({t, " fwd_en"},   32'(bus.fwd_en),           32'(e.fwd_en));
    check({t, " fwd_rd"},   32'(bus.fwd_rd),           32'(e.fwd_rd));
    check({t, " fwd_data"}, bus.fwd_data,              e.fwd_data);
    check({t, " lup"},      32'(bus.load_use_pending), 32'(e.lup));
    check({t, " taken"},    32'(bus.branch_taken),     32'(e.taken));
    check({t, " target"},   bus.branch_target,         e.target);
    check({t, " count"},    bus.taken_count,           e.count);
  endtask

  function automatic stim_t mk(input logic stall, input logic valid, input logic [31:0] alu,
                               input logic [4:0] rd, input logic rw, input logic mr,
                               input logic [1:0] bt, input logic [31:0] tgt);
    stim_t s;
    s.rst   = 1'b0;
    s.stall = stall;
    s.valid = valid;
    s.alu   = alu;
    s.zero  = (alu == 32'd0);
    s.rs2   = alu ^ 32'hA5A5_0000;
    s.rd    = rd;
    s.rw    = rw;
    s.mr    = mr;
    s.mw    = 1'b0;
    s.bt    = bt;
    s.tgt   = tgt;
    return s;
  endfunction

  function automatic exp_t ex(input logic valid, input logic [31:0] alu, input logic rw,
                              input logic fwd_en, input logic [4:0] fwd_rd,
                              input logic [31:0] fwd_data, input logic lup, input logic taken,
                              input logic [31:0] target, input logic [31:0] count);
    exp_t e;
    e.valid    = valid;
    e.alu      = alu;
    e.rw       = rw;
    e.fwd_en   = fwd_en;
    e.fwd_rd   = fwd_rd;
    e.fwd_data = fwd_data;
    e.lup      = lup;
    e.taken    = taken;
    e.target   = target;
    e.count    = count;
    return e;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    int kind;
    s.rst   = ($urandom_range(0, 99) == 0);
    s.stall = ($urandom_range(0, 3) == 0);
    s.valid = ($urandom_range(0, 4) != 0);
    s.alu   = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
    s.zero  = (s.alu == 32'd0);
    s.rs2   = $urandom;
    s.rd    = 5'($urandom_range(0, 31));
    s.tgt   = $urandom & 32'hFFFF_FFFC;
    s.rw    = 1'b0;
    s.mr    = 1'b0;
    s.mw    = 1'b0;
    s.bt    = 2'd0;
    kind    = $urandom_range(0, 3);
    case (kind)
      0:       s.rw = 1'b1;
      1:       begin s.rw = 1'b1; s.mr = 1'b1; end
      2:       s.mw = 1'b1;
      default: s.bt = 2'($urandom_range(0, 3));
    endcase
    return s;
  endfunction

  initial begin
    stim_t s;

    tbl[0]  = '{mk(0, 1, 32'h5,  5'd3, 1, 0, 2'd0, 32'h0),
                ex(1, 32'h5,  1, 1, 5'd3, 32'h5,  0, 0, 32'h0,   32'd0)};
    tbl[1]  = '{mk(0, 1, 32'h5,  5'd0, 1, 0, 2'd0, 32'h0),
                ex(1, 32'h5,  1, 0, 5'd0, 32'h5,  0, 0, 32'h0,   32'd0)};
    tbl[2]  = '{mk(0, 1, 32'h40, 5'd7, 1, 1, 2'd0, 32'h0),
                ex(1, 32'h40, 1, 0, 5'd7, 32'h40, 1, 0, 32'h0,   32'd0)};
    tbl[3]  = '{mk(0, 0, 32'h11, 5'd9, 1, 0, 2'd0, 32'h0),
                ex(0, 32'h11, 0, 0, 5'd9, 32'h11, 0, 0, 32'h0,   32'd0)};
    tbl[4]  = '{mk(0, 1, 32'h0,  5'd0, 0, 0, 2'd1, 32'h100),
                ex(1, 32'h0,  0, 0, 5'd0, 32'h0,  0, 1, 32'h100, 32'd0)};
    tbl[5]  = '{mk(0, 1, 32'h22, 5'd4, 1, 0, 2'd0, 32'h200),
                ex(0, 32'h0,  0, 0, 5'd0, 32'h0,  0, 0, 32'h100, 32'd1)};
    tbl[6]  = '{mk(0, 1, 32'h7,  5'd0, 0, 0, 2'd2, 32'h300),
                ex(1, 32'h7,  0, 0, 5'd0, 32'h7,  0, 1, 32'h300, 32'd1)};
    tbl[7]  = '{mk(0, 1, 32'h55, 5'd5, 1, 0, 2'd0, 32'h400),
                ex(0, 32'h7,  0, 0, 5'd0, 32'h7,  0, 0, 32'h300, 32'd2)};
    tbl[8]  = '{mk(0, 1, 32'h0,  5'd0, 0, 0, 2'd2, 32'h500),
                ex(1, 32'h0,  0, 0, 5'd0, 32'h0,  0, 0, 32'h500, 32'd2)};
    tbl[9]  = '{mk(0, 1, 32'h9,  5'd6, 1, 0, 2'd0, 32'h0),
                ex(1, 32'h9,  1, 1, 5'd6, 32'h9,  0, 0, 32'h0,   32'd2)};
    tbl[10] = '{mk(0, 1, 32'h0,  5'd0, 0, 0, 2'd3, 32'h600),
                ex(1, 32'h0,  0, 0, 5'd0, 32'h0,  0, 0, 32'h600, 32'd2)};
    tbl[11] = '{mk(0, 1, 32'h0,  5'd0, 0, 0, 2'd1, 32'h700),
                ex(1, 32'h0,  0, 0, 5'd0, 32'h0,  0, 1, 32'h700, 32'd2)};
    tbl[12] = '{mk(1, 1, 32'h33, 5'd8, 1, 0, 2'd0, 32'h800),
                ex(1, 32'h0,  0, 0, 5'd0, 32'h0,  0, 0, 32'h700, 32'd3)};
    tbl[13] = '{mk(1, 1, 32'h33, 5'd8, 1, 0, 2'd0, 32'h800),
                ex(1, 32'h0,  0, 0, 5'd0, 32'h0,  0, 0, 32'h700, 32'd3)};
    tbl[14] = '{mk(1, 1, 32'h33, 5'd8, 1, 0, 2'd0, 32'h800),
                ex(1, 32'h0,  0, 0, 5'd0, 32'h0,  0, 0, 32'h700, 32'd3)};
    tbl[15] = '{mk(0, 1, 32'h44, 5'd2, 1, 0, 2'd0, 32'h0),
                ex(1, 32'h44, 1, 1, 5'd2, 32'h44, 0, 0, 32'h0,   32'd3)};
    tbl[16] = '{mk(0, 1, 32'h0,  5'd0, 0, 0, 2'd1, 32'h900),
                ex(1, 32'h0,  0, 0, 5'd0, 32'h0,  0, 1, 32'h900, 32'd3)};
    tbl[17] = '{mk(1, 1, 32'h12, 5'd1, 1, 0, 2'd0, 32'h0),
                ex(0, 32'h0,  0, 0, 5'd0, 32'h0,  0, 0, 32'h0,   32'd0)};
    tbl[17].s.rst = 1'b1;
    tbl[18] = '{mk(0, 0, 32'h0,  5'd0, 0, 0, 2'd0, 32'h0),
                ex(0, 32'h0,  0, 0, 5'd0, 32'h0,  0, 0, 32'h0,   32'd0)};

    mem_entry   = '{default: '0};
    redirected  = 1'b0;
    taken_total = 32'd0;

    // Two reset cycles with garbage on every input.
    for (int i = 0; i < 2; i++) begin
      s     = randStim();
      s.rst = 1'b1;
      applyStimulus(s);
    end
    checkOutput("reset");
    check("reset taken_count", bus.taken_count, 32'd0);
    check("reset branch_taken", 32'(bus.branch_taken), 32'd0);

    for (int i = 0; i < 19; i++) begin
      applyStimulus(tbl[i].s);
      checkOutput($sformatf("vec%0d", i));
      checkTable(i, tbl[i].e);
    end

    // Counter wrap: preload the counter just below wrap, then take one branch.
    s     = mk(0, 0, 32'h0, 5'd0, 0, 0, 2'd0, 32'h0);
    s.rst = 1'b1;
    applyStimulus(s);
    force dut.taken_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.taken_count_q;
    taken_total = 32'hFFFF_FFFF;
    check("wrap preload", bus.taken_count, 32'hFFFF_FFFF);
    applyStimulus(mk(0, 1, 32'h0, 5'd0, 0, 0, 2'd1, 32'hA00));
    check("wrap pulse", 32'(bus.branch_taken), 32'd1);
    applyStimulus(mk(0, 0, 32'h0, 5'd0, 0, 0, 2'd0, 32'h0));
    check("wrap to zero", bus.taken_count, 32'd0);
    checkOutput("wrap");

    for (int i = 0; i < 3000; i++) begin
      applyStimulus(randStim());
      checkOutput($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
